// File: rtl/accumulator_pkg.sv
// Shared types and helpers for the accumulator stage.
// Holds the FSM state encoding and a width-generic sign-extension helper.
package accumulator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } acc_state_t;

    localparam int SEXT_MAX = 128;

    // Sign-extend the low w bits of v to SEXT_MAX bits.
    function automatic logic [SEXT_MAX-1:0] sign_ext(input logic [SEXT_MAX-1:0] v,
                                                     input int unsigned w);
        logic signed [SEXT_MAX-1:0] t;
        t = $signed(v << (SEXT_MAX - w));
        return t >>> (SEXT_MAX - w);
    endfunction

endpackage

// File: rtl/acc_adder.sv
// Combinational ACC_WIDTH signed adder; zero latency, no handshake.
// ACCUMULATOR_SATURATE_EN clamps on overflow, else wraps; ovf_o flags overflow in both builds.
module acc_adder
    import accumulator_pkg::*;
#(
    parameter int ACC_WIDTH = 48
) (
    input  logic [ACC_WIDTH-1:0] a_i,
    input  logic [ACC_WIDTH-1:0] b_i,
    output logic [ACC_WIDTH-1:0] sum_o,
    output logic                 ovf_o
);

    logic [ACC_WIDTH:0] sum_full;

    assign sum_full = {a_i[ACC_WIDTH-1], a_i} + {b_i[ACC_WIDTH-1], b_i};
    // The extra sign bit disagreeing with the MSB means the true sum left the range.
    assign ovf_o    = sum_full[ACC_WIDTH] ^ sum_full[ACC_WIDTH-1];

`ifdef ACCUMULATOR_SATURATE_EN
    always_comb begin
        sum_o = sum_full[ACC_WIDTH-1:0];
        if (ovf_o) begin
            sum_o = sum_full[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                        : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
    end
`else
    assign sum_o = sum_full[ACC_WIDTH-1:0];
`endif

endmodule

// File: rtl/accumulator_stage.sv
// Sums num_terms signed products into a wide accumulator; 1 product/cycle, result 1 cycle after last term.
// Holds result until out_ready; start accepted only in IDLE or on the DONE handshake. Macro: ACCUMULATOR_SATURATE_EN.
module accumulator_stage
    import accumulator_pkg::*;
#(
    parameter int IN_WIDTH  = 32,
    parameter int ACC_WIDTH = 48,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 arst_n_in,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] num_terms,
    input  logic                 prod_valid,
    output logic                 prod_ready,
    input  logic [IN_WIDTH-1:0]  prod_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic                 busy,
    output logic                 ovf
);

    acc_state_t           state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [ACC_WIDTH-1:0] addend;
    logic [ACC_WIDTH-1:0] add_sum;
    logic                 add_ovf;

    assign addend = ACC_WIDTH'(sign_ext(SEXT_MAX'(prod_data), IN_WIDTH));

    acc_adder #(
        .ACC_WIDTH(ACC_WIDTH)
    ) u_adder (
        .a_i  (acc_q),
        .b_i  (addend),
        .sum_o(add_sum),
        .ovf_o(add_ovf)
    );

`ifdef ACCUMULATOR_SATURATE_EN
    logic ovf_q, ovf_d;
    assign ovf = ovf_q;
`else
    logic unused_add_ovf;
    assign unused_add_ovf = add_ovf;
    assign ovf            = 1'b0;
`endif

    assign prod_ready = (state_q == ACC);
    assign out_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign out_data   = acc_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
`ifdef ACCUMULATOR_SATURATE_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE && out_ready) begin
                    state_d = IDLE;
                end
                // A start is taken from IDLE, or from DONE only alongside the result handshake.
                if (start && (state_q == IDLE || out_ready)) begin
                    acc_d   = '0;
                    cnt_d   = num_terms;
                    state_d = (num_terms == '0) ? DONE : ACC;
`ifdef ACCUMULATOR_SATURATE_EN
                    ovf_d   = 1'b0;
`endif
                end
            end
            ACC: begin
                if (prod_valid) begin
                    acc_d = add_sum;
                    cnt_d = cnt_q - CNT_WIDTH'(1);
`ifdef ACCUMULATOR_SATURATE_EN
                    ovf_d = ovf_q | add_ovf;
`endif
                    if (cnt_q == CNT_WIDTH'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
`ifdef ACCUMULATOR_SATURATE_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
`ifdef ACCUMULATOR_SATURATE_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

endmodule

// File: tb/tb_accumulator_stage.sv
// Directed bench for accumulator_stage: a 48-bit lane for the main function and a 32-bit lane for overflow.
// Expected results follow ACCUMULATOR_SATURATE_EN when it is defined.
module tb_accumulator_stage;

    logic        clk;
    logic        arst_n_in;
    logic        start;
    logic [15:0] num_terms;
    logic        prod_valid;
    logic [31:0] prod_data;
    logic        out_ready;

    logic        prod_ready;
    logic        out_valid;
    logic [47:0] out_data;
    logic        busy;
    logic        ovf;

    logic        prod_ready_n;
    logic        out_valid_n;
    logic [31:0] out_data_n;
    logic        busy_n;
    logic        ovf_n;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef ACCUMULATOR_SATURATE_EN
    localparam logic [63:0] EXP_OVF_DATA  = 64'h7FFFFFFF;
    localparam logic [63:0] EXP_OVF_FLAG  = 64'd1;
    localparam logic [63:0] EXP_OVF_DATA3 = 64'h7FFFFFFE;
`else
    localparam logic [63:0] EXP_OVF_DATA  = 64'h80000000;
    localparam logic [63:0] EXP_OVF_FLAG  = 64'd0;
    localparam logic [63:0] EXP_OVF_DATA3 = 64'h7FFFFFFF;
`endif

    accumulator_stage #(
        .IN_WIDTH (32),
        .ACC_WIDTH(48),
        .CNT_WIDTH(16)
    ) dut (
        .clk       (clk),
        .arst_n_in (arst_n_in),
        .start     (start),
        .num_terms (num_terms),
        .prod_valid(prod_valid),
        .prod_ready(prod_ready),
        .prod_data (prod_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .ovf       (ovf)
    );

    accumulator_stage #(
        .IN_WIDTH (32),
        .ACC_WIDTH(32),
        .CNT_WIDTH(16)
    ) dut_n (
        .clk       (clk),
        .arst_n_in (arst_n_in),
        .start     (start),
        .num_terms (num_terms),
        .prod_valid(prod_valid),
        .prod_ready(prod_ready_n),
        .prod_data (prod_data),
        .out_valid (out_valid_n),
        .out_ready (out_ready),
        .out_data  (out_data_n),
        .busy      (busy_n),
        .ovf       (ovf_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        arst_n_in  = 1'b0;
        start      = 1'b0;
        num_terms  = '0;
        prod_valid = 1'b0;
        prod_data  = '0;
        out_ready  = 1'b0;
        #12;
        chk("rst_busy",    64'(busy),       64'd0);
        chk("rst_valid",   64'(out_valid),  64'd0);
        chk("rst_ready",   64'(prod_ready), 64'd0);
        chk("rst_ovf",     64'(ovf),        64'd0);
        chk("rst_data",    64'(out_data),   64'd0);
        tick();
        arst_n_in = 1'b1;
        tick();

        // Basic sum 100 - 30 + 7
        out_ready = 1'b1;
        start = 1'b1; num_terms = 16'd3;
        tick();
        start = 1'b0;
        chk("basic_ready_t1", 64'(prod_ready), 64'd1);
        chk("basic_busy",     64'(busy),       64'd1);
        prod_valid = 1'b1; prod_data = 32'd100;
        tick();
        prod_data = -32'sd30;
        tick();
        prod_data = 32'd7;
        chk("basic_no_early_valid", 64'(out_valid), 64'd0);
        tick();
        prod_valid = 1'b0;
        chk("basic_valid", 64'(out_valid),  64'd1);
        chk("basic_data",  64'(out_data),   64'd77);
        chk("basic_ovf",   64'(ovf),        64'd0);
        chk("basic_pr0",   64'(prod_ready), 64'd0);
        tick();
        chk("basic_idle",  64'(busy),       64'd0);

        // Zero terms, with a product offered that must not be taken
        start = 1'b1; num_terms = 16'd0; prod_valid = 1'b1; prod_data = 32'd55;
        tick();
        start = 1'b0;
        chk("zero_valid", 64'(out_valid),  64'd1);
        chk("zero_data",  64'(out_data),   64'd0);
        chk("zero_pr",    64'(prod_ready), 64'd0);
        tick();
        prod_valid = 1'b0;
        chk("zero_idle",  64'(busy),       64'd0);

        // Backpressure, with an ignored start in the stall window
        out_ready = 1'b0;
        start = 1'b1; num_terms = 16'd2;
        tick();
        start = 1'b0;
        prod_valid = 1'b1; prod_data = 32'd10;
        tick();
        prod_data = 32'd20;
        tick();
        prod_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 64'(out_valid),  64'd1);
            chk("bp_data",  64'(out_data),   64'd30);
            chk("bp_pr",    64'(prod_ready), 64'd0);
            start = (i == 2); num_terms = 16'd7;
            tick();
        end
        start = 1'b0;
        chk("bp_hold_valid", 64'(out_valid), 64'd1);
        chk("bp_hold_data",  64'(out_data),  64'd30);

        // Back-to-back: handshake and start together
        out_ready = 1'b1; start = 1'b1; num_terms = 16'd2;
        tick();
        start = 1'b0; out_ready = 1'b0;
        chk("b2b_ready", 64'(prod_ready), 64'd1);
        chk("b2b_valid", 64'(out_valid),  64'd0);
        prod_valid = 1'b1; prod_data = -32'sd5;
        tick();
        prod_data = -32'sd6;
        tick();
        prod_valid = 1'b0;
        chk("b2b_data", 64'(out_data), 64'h0000_FFFF_FFFF_FFF5);
        out_ready = 1'b1;
        tick();

        // Reset in the middle of an accumulation
        start = 1'b1; num_terms = 16'd4;
        tick();
        start = 1'b0;
        prod_valid = 1'b1; prod_data = 32'd1;
        tick();
        prod_data = 32'd2;
        tick();
        arst_n_in = 1'b0;
        #1;
        chk("mid_rst_busy",  64'(busy),       64'd0);
        chk("mid_rst_valid", 64'(out_valid),  64'd0);
        chk("mid_rst_ready", 64'(prod_ready), 64'd0);
        prod_valid = 1'b0;
        tick();
        arst_n_in = 1'b1;
        start = 1'b1; num_terms = 16'd1;
        tick();
        start = 1'b0;
        prod_valid = 1'b1; prod_data = 32'd5;
        tick();
        prod_valid = 1'b0;
        chk("mid_rst_sum", 64'(out_data), 64'd5);
        tick();

        // Overflow on the 32-bit lane; the 48-bit lane holds the exact sum
        start = 1'b1; num_terms = 16'd2;
        tick();
        start = 1'b0;
        prod_valid = 1'b1; prod_data = 32'h7FFF_FFFF;
        tick();
        prod_data = 32'd1;
        tick();
        prod_valid = 1'b0;
        chk("ovf_valid",   64'(out_valid_n), 64'd1);
        chk("ovf_data",    64'(out_data_n),  EXP_OVF_DATA);
        chk("ovf_flag",    64'(ovf_n),       EXP_OVF_FLAG);
        chk("wide_data",   64'(out_data),    64'h8000_0000);
        chk("wide_ovf",    64'(ovf),         64'd0);
        tick();

        // Sticky flag and continued accumulation after a clamp
        start = 1'b1; num_terms = 16'd3;
        tick();
        start = 1'b0;
        prod_valid = 1'b1; prod_data = 32'h7FFF_FFFF;
        tick();
        prod_data = 32'd1;
        tick();
        prod_data = 32'hFFFF_FFFF;
        tick();
        prod_valid = 1'b0;
        chk("ovf3_data", 64'(out_data_n), EXP_OVF_DATA3);
        chk("ovf3_flag", 64'(ovf_n),      EXP_OVF_FLAG);

        // Flag clears on the next accepted start
        start = 1'b1; num_terms = 16'd0;
        tick();
        start = 1'b0;
        chk("ovf_clr_flag",  64'(ovf_n),       64'd0);
        chk("ovf_clr_valid", 64'(out_valid_n), 64'd1);
        chk("ovf_clr_data",  64'(out_data_n),  64'd0);
        tick();
        chk("end_idle", 64'(busy_n), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
